// File: rtl/cdb_arbiter_if.sv
// Common Data Bus handshake bundle between the functional units and the
// CDB arbiter. The arbiter side is the master: it drives grants and status,
// and the functional units (slave side) drive their requests.
interface cdb_arbiter_if #(
   parameter int NUM_UNITS = 4,
   parameter int IDX_W     = 2
);
   logic [NUM_UNITS-1:0] CDB_rts;
   logic [NUM_UNITS-1:0] CDB_xmit;
   logic                 grant_valid;
   logic [IDX_W-1:0]     grant_id;
   logic                 dropped_request;
   logic [15:0]          grant_count;

   modport master (
      input  CDB_rts,
      output CDB_xmit, grant_valid, grant_id, dropped_request, grant_count
   );

   modport slave (
      output CDB_rts,
      input  CDB_xmit, grant_valid, grant_id, dropped_request, grant_count
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter. Grants the bus to one functional unit
// at a time for a fixed number of cycles, then inserts one turnaround cycle.
// The unit that just finished is masked for one arbitration so a request that
// lingers one cycle after its CDB_xmit falls is not mistaken for a new one.
module cdb_arbiter #(
   parameter int NUM_UNITS   = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int IDX_W       = 2
) (
   input logic           clock,
   input logic           reset_n,
   cdb_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   state_t               state;
   logic [IDX_W-1:0]     ptr;
   logic [IDX_W-1:0]     last_winner;
   logic [IDX_W-1:0]     cur;
   logic [3:0]           hold_cnt;
   logic [NUM_UNITS-1:0] req;
   logic [IDX_W-1:0]     pick;
   logic                 found;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] w);
      return (int'(w) == NUM_UNITS - 1) ? '0 : w + IDX_W'(1);
   endfunction

   // Candidate requests: the previous winner is hidden during turnaround
   always_comb begin
      req = bus.CDB_rts;
      if (state == RELEASE) begin
         req = bus.CDB_rts & ~(NUM_UNITS'(1) << last_winner);
      end
   end

   // Round-robin search for the first candidate at or after ptr
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         j = (int'(ptr) + i) % NUM_UNITS;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = IDX_W'(j);
         end
      end
   end

   // Arbiter FSM with registered grant and status outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state               <= IDLE;
         ptr                 <= '0;
         last_winner         <= '0;
         cur                 <= '0;
         hold_cnt            <= '0;
         bus.CDB_xmit        <= '0;
         bus.grant_valid     <= 1'b0;
         bus.grant_id        <= '0;
         bus.dropped_request <= 1'b0;
         bus.grant_count     <= '0;
      end else begin
         bus.dropped_request <= 1'b0;
         case (state)
            IDLE, RELEASE: begin
               if (found) begin
                  bus.CDB_xmit    <= NUM_UNITS'(1) << pick;
                  bus.grant_valid <= 1'b1;
                  bus.grant_id    <= pick;
                  cur             <= pick;
                  hold_cnt        <= HOLD_LOAD;
                  state           <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
            GRANT: begin
               if (!bus.CDB_rts[cur]) begin
                  // Unit withdrew mid-grant: abort without counting it
                  bus.CDB_xmit        <= '0;
                  bus.grant_valid     <= 1'b0;
                  bus.grant_id        <= '0;
                  bus.dropped_request <= 1'b1;
                  ptr                 <= next_idx(cur);
                  state               <= RELEASE;
               end else if (hold_cnt == 4'd0) begin
                  bus.CDB_xmit    <= '0;
                  bus.grant_valid <= 1'b0;
                  bus.grant_id    <= '0;
                  ptr             <= next_idx(cur);
                  last_winner     <= cur;
                  bus.grant_count <= sat_inc(bus.grant_count);
                  state           <= RELEASE;
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: one DUT with the default two-cycle hold
// and a second with single-cycle grants.
module tb_cdb_arbiter;
   logic clock;
   logic reset_n;
   int   checks;
   int   failures;

   cdb_arbiter_if #(.NUM_UNITS(4), .IDX_W(2)) bus0 ();
   cdb_arbiter_if #(.NUM_UNITS(4), .IDX_W(2)) bus1 ();

   cdb_arbiter #(.NUM_UNITS(4), .HOLD_CYCLES(2), .IDX_W(2)) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus0)
   );

   cdb_arbiter #(.NUM_UNITS(4), .HOLD_CYCLES(1), .IDX_W(2)) u_dut1 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      bus0.CDB_rts = 4'b0000;
      bus1.CDB_rts = 4'b0000;
      reset_n = 1'b0;
      #2;
      checks++;
      if ({bus0.CDB_xmit, bus0.grant_valid, bus0.grant_id, bus0.dropped_request, bus0.grant_count} !== 24'd0) begin
         failures++;
         $display("FAIL reset_outputs_dut0: got xmit=%b gv=%b id=%0d drop=%b cnt=%0d, want all zero",
                  bus0.CDB_xmit, bus0.grant_valid, bus0.grant_id, bus0.dropped_request, bus0.grant_count);
      end
      checks++;
      if ({bus1.CDB_xmit, bus1.grant_valid, bus1.grant_id, bus1.dropped_request, bus1.grant_count} !== 24'd0) begin
         failures++;
         $display("FAIL reset_outputs_dut1: got xmit=%b gv=%b id=%0d drop=%b cnt=%0d, want all zero",
                  bus1.CDB_xmit, bus1.grant_valid, bus1.grant_id, bus1.dropped_request, bus1.grant_count);
      end
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_single_request();
      bus0.CDB_rts = 4'b0100;
      #1;
      checks++;
      if (bus0.CDB_xmit !== 4'b0000) begin
         failures++;
         $display("FAIL single_no_comb_path: got xmit=%b, want 0000", bus0.CDB_xmit);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({bus0.CDB_xmit, bus0.grant_valid, bus0.grant_id} !== {4'b0100, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL single_grant_cycle%0d: got xmit=%b gv=%b id=%0d, want xmit=0100 gv=1 id=2",
                     c, bus0.CDB_xmit, bus0.grant_valid, bus0.grant_id);
         end
      end
      tick();
      checks++;
      if ({bus0.CDB_xmit, bus0.grant_valid, bus0.grant_id, bus0.grant_count} !== {4'b0000, 1'b0, 2'd0, 16'd1}) begin
         failures++;
         $display("FAIL single_release: got xmit=%b gv=%b id=%0d cnt=%0d, want xmit=0000 gv=0 id=0 cnt=1",
                  bus0.CDB_xmit, bus0.grant_valid, bus0.grant_id, bus0.grant_count);
      end
      bus0.CDB_rts = 4'b0000;
      tick();
      checks++;
      if (bus0.CDB_xmit !== 4'b0000) begin
         failures++;
         $display("FAIL single_idle_after: got xmit=%b, want 0000", bus0.CDB_xmit);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp;
      do_reset();
      bus0.CDB_rts = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         exp = 4'b0001 << (g % 4);
         for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) exp = 4'b0000;
            checks++;
            if (bus0.CDB_xmit !== exp || bus0.grant_valid !== (exp != 4'b0000)) begin
               failures++;
               $display("FAIL rr_grant%0d_cycle%0d: got xmit=%b gv=%b, want xmit=%b gv=%b",
                        g, c, bus0.CDB_xmit, bus0.grant_valid, exp, (exp != 4'b0000));
            end
         end
      end
      checks++;
      if (bus0.grant_count !== 16'd5) begin
         failures++;
         $display("FAIL rr_count: got %0d, want 5", bus0.grant_count);
      end
      bus0.CDB_rts = 4'b0000;
      tick();
   endtask

   task automatic test_lingering_request();
      do_reset();
      bus0.CDB_rts = 4'b0011;
      tick();
      tick();
      checks++;
      if (bus0.CDB_xmit !== 4'b0001) begin
         failures++;
         $display("FAIL linger_first: got xmit=%b, want 0001", bus0.CDB_xmit);
      end
      tick();
      checks++;
      if (bus0.CDB_xmit !== 4'b0000) begin
         failures++;
         $display("FAIL linger_turnaround: got xmit=%b, want 0000", bus0.CDB_xmit);
      end
      tick();
      checks++;
      if ({bus0.CDB_xmit, bus0.grant_id} !== {4'b0010, 2'd1}) begin
         failures++;
         $display("FAIL linger_masked: got xmit=%b id=%0d, want xmit=0010 id=1", bus0.CDB_xmit, bus0.grant_id);
      end
      bus0.CDB_rts = 4'b0000;
      tick();
      tick();
      tick();
   endtask

   task automatic test_abort();
      do_reset();
      bus0.CDB_rts = 4'b0010;
      tick();
      tick();
      tick();
      bus0.CDB_rts = 4'b0000;
      tick();
      bus0.CDB_rts = 4'b1000;
      tick();
      checks++;
      if ({bus0.CDB_xmit, bus0.grant_id, bus0.grant_count} !== {4'b1000, 2'd3, 16'd1}) begin
         failures++;
         $display("FAIL abort_grant3: got xmit=%b id=%0d cnt=%0d, want xmit=1000 id=3 cnt=1",
                  bus0.CDB_xmit, bus0.grant_id, bus0.grant_count);
      end
      bus0.CDB_rts = 4'b0000;
      tick();
      checks++;
      if ({bus0.CDB_xmit, bus0.grant_valid, bus0.dropped_request, bus0.grant_count} !== {4'b0000, 1'b0, 1'b1, 16'd1}) begin
         failures++;
         $display("FAIL abort_clear: got xmit=%b gv=%b drop=%b cnt=%0d, want xmit=0000 gv=0 drop=1 cnt=1",
                  bus0.CDB_xmit, bus0.grant_valid, bus0.dropped_request, bus0.grant_count);
      end
      tick();
      checks++;
      if (bus0.dropped_request !== 1'b0) begin
         failures++;
         $display("FAIL abort_pulse_once: got drop=%b, want 0", bus0.dropped_request);
      end
      bus0.CDB_rts = 4'b0110;
      tick();
      checks++;
      if ({bus0.CDB_xmit, bus0.grant_id} !== {4'b0010, 2'd1}) begin
         failures++;
         $display("FAIL abort_next_ptr: got xmit=%b id=%0d, want xmit=0010 id=1", bus0.CDB_xmit, bus0.grant_id);
      end
      bus0.CDB_rts = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_async_reset();
      bus0.CDB_rts = 4'b1111;
      tick();
      checks++;
      if (bus0.grant_valid !== 1'b1) begin
         failures++;
         $display("FAIL areset_pre_grant: got gv=%b, want 1", bus0.grant_valid);
      end
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus0.CDB_xmit, bus0.grant_valid, bus0.grant_id, bus0.dropped_request, bus0.grant_count} !== 24'd0) begin
         failures++;
         $display("FAIL areset_immediate: got xmit=%b gv=%b id=%0d drop=%b cnt=%0d, want all zero",
                  bus0.CDB_xmit, bus0.grant_valid, bus0.grant_id, bus0.dropped_request, bus0.grant_count);
      end
      tick();
      #2;
      reset_n = 1'b1;
      tick();
      checks++;
      if ({bus0.CDB_xmit, bus0.grant_id} !== {4'b0001, 2'd0}) begin
         failures++;
         $display("FAIL areset_first_grant: got xmit=%b id=%0d, want xmit=0001 id=0", bus0.CDB_xmit, bus0.grant_id);
      end
      bus0.CDB_rts = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_hold_one();
      logic [3:0] exp;
      bus1.CDB_rts = 4'b0011;
      for (int g = 0; g < 4; g++) begin
         exp = 4'b0001 << (g % 2);
         tick();
         checks++;
         if ({bus1.CDB_xmit, bus1.grant_count} !== {exp, 16'(g)}) begin
            failures++;
            $display("FAIL hold1_grant%0d: got xmit=%b cnt=%0d, want xmit=%b cnt=%0d",
                     g, bus1.CDB_xmit, bus1.grant_count, exp, g);
         end
         tick();
         checks++;
         if ({bus1.CDB_xmit, bus1.grant_count} !== {4'b0000, 16'(g + 1)}) begin
            failures++;
            $display("FAIL hold1_gap%0d: got xmit=%b cnt=%0d, want xmit=0000 cnt=%0d",
                     g, bus1.CDB_xmit, bus1.grant_count, g + 1);
         end
      end
      bus1.CDB_rts = 4'b0000;
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b1;
      bus0.CDB_rts = 4'b0000;
      bus1.CDB_rts = 4'b0000;
      tick();
      test_reset();
      test_single_request();
      test_round_robin();
      test_lingering_request();
      test_abort();
      test_async_reset();
      test_hold_one();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
